// File: rtl/tx_router_param.sv
// tx_router_param: input FIFO routed by the word's top select bits into
// per-destination FIFOs, with programmable thresholds and a control FSM.
module tx_router_param #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 2,
    parameter int SEL_WIDTH  = 1,
    localparam int NUM_DEST  = 2**SEL_WIDTH,
    localparam int CW        = ADDR_WIDTH + 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           init,
    input  logic                           wr_enable,
    input  logic [DATA_WIDTH-1:0]          data_in,
    input  logic [CW-1:0]                  umbral_alto,
    input  logic [CW-1:0]                  umbral_bajo,
    input  logic [NUM_DEST-1:0]            pop,
    output logic [NUM_DEST*DATA_WIDTH-1:0] data_out,
    output logic [NUM_DEST-1:0]            valid_out,
    output logic [NUM_DEST-1:0]            empty,
    output logic [NUM_DEST-1:0]            almost_full,
    output logic [NUM_DEST-1:0]            almost_empty,
    output logic                           pause_out,
    output logic                           error_out,
    output logic                           active_out,
    output logic                           idle_out
);

    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    localparam logic [2:0] S_RESET  = 3'd0;
    localparam logic [2:0] S_INIT   = 3'd1;
    localparam logic [2:0] S_IDLE   = 3'd2;
    localparam logic [2:0] S_ACTIVE = 3'd3;
    localparam logic [2:0] S_ERROR  = 3'd4;

    logic [2:0] state_q, state_d;
    logic       err_q, act_q, idle_q;
    logic [CW-1:0] alto_q, bajo_q;

    logic [DATA_WIDTH-1:0] in_mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] in_wp_q, in_rp_q;
    logic [CW-1:0]         in_cnt_q;

    logic [DATA_WIDTH-1:0] d_mem_q [NUM_DEST][DEPTH];
    logic [ADDR_WIDTH-1:0] d_wp_q  [NUM_DEST];
    logic [ADDR_WIDTH-1:0] d_rp_q  [NUM_DEST];
    logic [CW-1:0]         d_cnt_q [NUM_DEST];

    logic [NUM_DEST*DATA_WIDTH-1:0] dout_q;
    logic [NUM_DEST-1:0]            valid_q;

    logic                 wr_st, wr_acc, ovf, xfer, all_zero;
    logic [SEL_WIDTH-1:0] hsel;
    logic [NUM_DEST-1:0]  push, rd;

    // Fullness is judged on the pre-edge count, before any transfer-pop.
    assign wr_st  = (state_q == S_IDLE) || (state_q == S_ACTIVE);
    assign wr_acc = wr_st && wr_enable && (in_cnt_q != FULL);
    assign ovf    = wr_st && wr_enable && (in_cnt_q == FULL);

    assign hsel = in_mem_q[in_rp_q][DATA_WIDTH-1 -: SEL_WIDTH];
    assign xfer = (in_cnt_q != '0) && !almost_full[hsel]
                  && (d_cnt_q[hsel] != FULL);

    always_comb begin
        empty        = '0;
        almost_full  = '0;
        almost_empty = '0;
        rd           = '0;
        all_zero     = (in_cnt_q == '0);
        for (int d = 0; d < NUM_DEST; d++) begin
            empty[d]        = (d_cnt_q[d] == '0);
            almost_full[d]  = (d_cnt_q[d] >= alto_q);
            almost_empty[d] = (d_cnt_q[d] <= bajo_q);
            rd[d]           = pop[d] && (d_cnt_q[d] != '0);
            all_zero        = all_zero && (d_cnt_q[d] == '0);
        end
    end

    always_comb begin
        push = '0;
        for (int d = 0; d < NUM_DEST; d++) begin
            push[d] = xfer && (hsel == SEL_WIDTH'(d));
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET:  if (init) state_d = S_INIT;
            S_INIT:   if (!init) state_d = S_IDLE;
            S_IDLE: begin
                if (init)        state_d = S_INIT;
                else if (ovf)    state_d = S_ERROR;
                else if (wr_acc) state_d = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (ovf)                       state_d = S_ERROR;
                else if (all_zero && !wr_acc)  state_d = S_IDLE;
            end
            S_ERROR:  state_d = S_ERROR;
            default:  state_d = S_RESET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_RESET;
            err_q    <= 1'b0;
            act_q    <= 1'b0;
            idle_q   <= 1'b0;
            alto_q   <= FULL;
            bajo_q   <= '0;
            in_wp_q  <= '0;
            in_rp_q  <= '0;
            in_cnt_q <= '0;
            dout_q   <= '0;
            valid_q  <= '0;
            for (int d = 0; d < NUM_DEST; d++) begin
                d_wp_q[d]  <= '0;
                d_rp_q[d]  <= '0;
                d_cnt_q[d] <= '0;
            end
        end else begin
            state_q <= state_d;
            err_q   <= (state_d == S_ERROR);
            act_q   <= (state_d == S_ACTIVE);
            idle_q  <= (state_d == S_IDLE);
            if (state_q == S_INIT) begin
                alto_q <= umbral_alto;
                bajo_q <= umbral_bajo;
            end
            if (wr_acc) in_wp_q <= in_wp_q + ADDR_WIDTH'(1);
            if (xfer)   in_rp_q <= in_rp_q + ADDR_WIDTH'(1);
            in_cnt_q <= in_cnt_q + CW'(wr_acc) - CW'(xfer);
            valid_q  <= rd;
            for (int d = 0; d < NUM_DEST; d++) begin
                if (push[d]) d_wp_q[d] <= d_wp_q[d] + ADDR_WIDTH'(1);
                if (rd[d]) begin
                    d_rp_q[d] <= d_rp_q[d] + ADDR_WIDTH'(1);
                    dout_q[d*DATA_WIDTH +: DATA_WIDTH] <= d_mem_q[d][d_rp_q[d]];
                end
                d_cnt_q[d] <= d_cnt_q[d] + CW'(push[d]) - CW'(rd[d]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) in_mem_q[in_wp_q] <= data_in;
        for (int d = 0; d < NUM_DEST; d++) begin
            if (push[d]) d_mem_q[d][d_wp_q[d]] <= in_mem_q[in_rp_q];
        end
    end

    assign data_out   = dout_q;
    assign valid_out  = valid_q;
    assign pause_out  = (in_cnt_q >= alto_q);
    assign error_out  = err_q;
    assign active_out = act_q;
    assign idle_out   = idle_q;

endmodule

// File: tb/tb_tx_router_param.sv
// Bench for tx_router_param: queue-level reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_tx_router_param;

    localparam int M_RESET  = 0;
    localparam int M_INIT   = 1;
    localparam int M_IDLE   = 2;
    localparam int M_ACTIVE = 3;
    localparam int M_ERROR  = 4;

    logic        clk, reset, init, wr_enable;
    logic [5:0]  data_in;
    logic [2:0]  umbral_alto, umbral_bajo;
    logic [1:0]  pop;
    logic [11:0] data_out;
    logic [1:0]  valid_out, empty, almost_full, almost_empty;
    logic        pause_out, error_out, active_out, idle_out;

    int tests = 0;
    int fails = 0;

    tx_router_param #(.DATA_WIDTH(6), .ADDR_WIDTH(2), .SEL_WIDTH(1)) dut (
        .clk(clk), .reset(reset), .init(init), .wr_enable(wr_enable),
        .data_in(data_in), .umbral_alto(umbral_alto),
        .umbral_bajo(umbral_bajo), .pop(pop), .data_out(data_out),
        .valid_out(valid_out), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .pause_out(pause_out),
        .error_out(error_out), .active_out(active_out), .idle_out(idle_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", n, a, e, $time);
        end
    endtask

    // Reference model: plain queues and the FSM rules.
    logic [5:0]  inq [$];
    logic [5:0]  dq [2][$];
    int          ms = M_RESET;
    int          malto = 4;
    int          mbajo = 0;
    logic [11:0] mdout = '0;
    logic [1:0]  mvalid = '0;

    task automatic model_step();
        int  insz, hd;
        int  dsz [2];
        bit  wst, acc, ovf, xf, allz;
        if (reset) begin
            inq.delete();
            dq[0].delete();
            dq[1].delete();
            ms = M_RESET; malto = 4; mbajo = 0;
            mdout = '0; mvalid = '0;
            return;
        end
        insz = inq.size();
        dsz[0] = dq[0].size();
        dsz[1] = dq[1].size();
        allz = (insz == 0) && (dsz[0] == 0) && (dsz[1] == 0);
        wst = (ms == M_IDLE) || (ms == M_ACTIVE);
        acc = wst && wr_enable && (insz < 4);
        ovf = wst && wr_enable && (insz == 4);
        xf = 0;
        hd = 0;
        if (insz > 0) begin
            hd = int'(inq[0][5]);
            xf = (dsz[hd] < malto) && (dsz[hd] < 4);
        end
        mvalid = '0;
        for (int d = 0; d < 2; d++) begin
            if (pop[d] && dsz[d] > 0) begin
                mdout[d*6 +: 6] = dq[d].pop_front();
                mvalid[d] = 1'b1;
            end
        end
        if (xf) dq[hd].push_back(inq.pop_front());
        if (acc) inq.push_back(data_in);
        if (ms == M_INIT) begin
            malto = int'(umbral_alto);
            mbajo = int'(umbral_bajo);
        end
        case (ms)
            M_RESET:  if (init) ms = M_INIT;
            M_INIT:   if (!init) ms = M_IDLE;
            M_IDLE: begin
                if (init)     ms = M_INIT;
                else if (ovf) ms = M_ERROR;
                else if (acc) ms = M_ACTIVE;
            end
            M_ACTIVE: begin
                if (ovf)               ms = M_ERROR;
                else if (allz && !acc) ms = M_IDLE;
            end
            default: ;
        endcase
    endtask

    task automatic compare();
        logic [1:0] e, af, ae;
        for (int d = 0; d < 2; d++) begin
            e[d]  = (dq[d].size() == 0);
            af[d] = (dq[d].size() >= malto);
            ae[d] = (dq[d].size() <= mbajo);
        end
        chk("data_out", 32'(data_out), 32'(mdout));
        chk("valid_out", 32'(valid_out), 32'(mvalid));
        chk("empty", 32'(empty), 32'(e));
        chk("almost_full", 32'(almost_full), 32'(af));
        chk("almost_empty", 32'(almost_empty), 32'(ae));
        chk("pause_out", 32'(pause_out), 32'(inq.size() >= malto));
        chk("error_out", 32'(error_out), 32'(ms == M_ERROR));
        chk("active_out", 32'(active_out), 32'(ms == M_ACTIVE));
        chk("idle_out", 32'(idle_out), 32'(ms == M_IDLE));
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            #1;
            compare();
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic init_seq(input logic [2:0] a, input logic [2:0] b);
        reset = 1'b1; init = 1'b0; wr_enable = 1'b0; pop = '0;
        cyc();
        reset = 1'b0; init = 1'b1; umbral_alto = a; umbral_bajo = b;
        cyc();
        init = 1'b0;
        cyc();
    endtask

    logic [5:0]  rx0 [$];
    logic [5:0]  rx1 [$];
    logic [5:0]  ex0 [$];
    logic [5:0]  ex1 [$];
    logic [31:0] iv;
    logic [11:0] save;
    logic [5:0]  last, first;
    int          npulse, bad;

    initial begin
        reset = 1'b1; init = 1'b0; wr_enable = 1'b0; data_in = '0;
        umbral_alto = 3'd0; umbral_bajo = 3'd0; pop = '0;
        cyc();
        cyc();
        chk("rst data_out", 32'(data_out), 0);
        chk("rst valid_out", 32'(valid_out), 0);
        chk("rst flags", {29'd0, error_out, active_out, idle_out}, 0);
        chk("rst pause", 32'(pause_out), 0);
        chk("rst almost_full", 32'(almost_full), 0);

        reset = 1'b0; init = 1'b1; umbral_alto = 3'd3; umbral_bajo = 3'd1;
        cyc();
        chk("init not idle", 32'(idle_out), 0);
        init = 1'b0;
        cyc();
        chk("idle after init", 32'(idle_out), 1);

        // Routing
        pop = 2'b11; wr_enable = 1'b1; data_in = 6'b000101;
        cyc();
        data_in = 6'b100010;
        cyc();
        wr_enable = 1'b0;
        cyc();
        chk("route v0", 32'(valid_out), 32'(2'b01));
        chk("route d0", 32'(data_out[5:0]), 32'(6'b000101));
        cyc();
        chk("route v1", 32'(valid_out), 32'(2'b10));
        chk("route d1", 32'(data_out[11:6]), 32'(6'b100010));
        cyc();
        cyc();
        chk("route idle", 32'(idle_out), 1);

        // Back-pressure then overflow
        pop = 2'b00; wr_enable = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            data_in = 6'(i);
            cyc();
        end
        chk("bp almost_full0", 32'(almost_full[0]), 1);
        chk("bp pause", 32'(pause_out), 1);
        chk("bp no err", 32'(error_out), 0);
        data_in = 6'd8;
        cyc();
        wr_enable = 1'b0;
        chk("ovf err", 32'(error_out), 1);
        pop = 2'b01; npulse = 0; last = '0; first = '0;
        for (int i = 0; i < 14; i++) begin
            cyc();
            if (valid_out[0]) begin
                if (npulse == 0) first = data_out[5:0];
                npulse++;
                last = data_out[5:0];
            end
        end
        chk("drain first", 32'(first), 1);
        chk("drain count", 32'(npulse), 7);
        chk("drain last", 32'(last), 7);
        pop = 2'b00; init = 1'b1;
        cyc();
        init = 1'b0;
        cyc();
        chk("err sticky", 32'(error_out), 1);

        // Head-of-line blocking
        init_seq(3'd3, 3'd1);
        wr_enable = 1'b1;
        data_in = 6'd10; cyc();
        data_in = 6'd11; cyc();
        data_in = 6'd12; cyc();
        data_in = 6'd13; cyc();
        data_in = 6'b100111; cyc();
        wr_enable = 1'b0;
        for (int i = 0; i < 4; i++) cyc();
        chk("hol blocked", 32'(empty[1]), 1);
        pop = 2'b01;
        cyc();
        chk("hol pop0", 32'(data_out[5:0]), 10);
        pop = 2'b00;
        for (int i = 0; i < 3; i++) cyc();
        chk("hol freed", 32'(empty[1]), 0);
        pop = 2'b10;
        cyc();
        chk("hol d1", 32'(data_out[11:6]), 32'(6'b100111));
        pop = 2'b00;

        // Wrap-around stream
        init_seq(3'd3, 3'd1);
        pop = 2'b11; wr_enable = 1'b1;
        for (int i = 0; i < 39; i++) begin
            iv = i;
            data_in = {iv[0], iv[4:0]};
            if (iv[0]) ex1.push_back(data_in);
            else       ex0.push_back(data_in);
            cyc();
            if (valid_out[0]) rx0.push_back(data_out[5:0]);
            if (valid_out[1]) rx1.push_back(data_out[11:6]);
        end
        wr_enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (valid_out[0]) rx0.push_back(data_out[5:0]);
            if (valid_out[1]) rx1.push_back(data_out[11:6]);
        end
        chk("stream n0", 32'(rx0.size()), 20);
        chk("stream n1", 32'(rx1.size()), 19);
        bad = 0;
        for (int k = 0; k < rx0.size() && k < ex0.size(); k++)
            if (rx0[k] !== ex0[k]) bad++;
        for (int k = 0; k < rx1.size() && k < ex1.size(); k++)
            if (rx1[k] !== ex1[k]) bad++;
        chk("stream order", 32'(bad), 0);

        // Pop while empty
        save = data_out;
        for (int i = 0; i < 3; i++) cyc();
        chk("empty pop hold", 32'(data_out), 32'(save));
        chk("empty pop valid", 32'(valid_out), 0);
        chk("empty pop err", 32'(error_out), 0);
        pop = 2'b00;

        // umbral_alto = 0 blocks every transfer
        init_seq(3'd0, 3'd0);
        chk("alto0 pause", 32'(pause_out), 1);
        wr_enable = 1'b1; data_in = 6'd9;
        cyc();
        wr_enable = 1'b0;
        for (int i = 0; i < 3; i++) cyc();
        chk("alto0 blocked", 32'(empty[0]), 1);

        // umbral_alto > DEPTH: full blocks, almost_full never rises
        init_seq(3'd5, 3'd0);
        wr_enable = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            data_in = 6'(i);
            cyc();
        end
        wr_enable = 1'b0;
        for (int i = 0; i < 3; i++) cyc();
        chk("alto5 af", 32'(almost_full[0]), 0);
        chk("alto5 pause", 32'(pause_out), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
